// File: rtl/riscv_pkg.sv
// Shared IF-stage definitions: fetch FSM states, instruction width and NOP encoding.
package riscv_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    KILL
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction and its PC while ID is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   rel,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [ADDR_WIDTH-1:0]  in_pc,
  output logic                   full,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  logic                   full_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  // Clear (redirect) wins over a same-cycle load or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (clear) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load) begin
      full_q  <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end else if (rel) begin
      full_q  <= 1'b0;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues single-outstanding fetches, applies
// EX/trap redirects, drives pipeline flushes and squashes stale responses.
module fetch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_redirect,
  input  logic [ADDR_WIDTH-1:0]  ex_target,
  input  logic                   trap_redirect,
  input  logic [ADDR_WIDTH-1:0]  trap_target,
  input  logic                   hazard_stall,
  output logic                   fetch_req_valid,
  output logic [ADDR_WIDTH-1:0]  fetch_req_addr,
  input  logic                   fetch_req_ready,
  input  logic                   fetch_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] fetch_rsp_instr,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic [CNT_WIDTH-1:0]   redirect_count
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  tag_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  tgt;
  logic                   handshake;
  logic                   rsp_keep;
  logic                   skid_full, skid_load, skid_rel;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  assign redirect  = trap_redirect | ex_redirect;
  assign tgt       = trap_redirect ? trap_target : ex_target;
  assign rsp_keep  = (state_q == WAIT) && fetch_rsp_valid && !redirect;
  assign skid_load = rsp_keep && hazard_stall;
  assign skid_rel  = skid_full && !hazard_stall && !redirect;
  assign handshake = fetch_req_valid && fetch_req_ready;

  fetch_skid_buf #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .rel     (skid_rel),
    .clear   (redirect),
    .in_instr(fetch_rsp_instr),
    .in_pc   (tag_q),
    .full    (skid_full),
    .instr   (skid_instr),
    .pc      (skid_pc)
  );

  // Request and flush are qualified by rst_n so every output idles while reset is held.
  always_comb begin
    fetch_req_valid = 1'b0;
    if (rst_n && !redirect && !skid_full) begin
      fetch_req_valid = (state_q == ISSUE) ||
                        ((state_q == WAIT) && fetch_rsp_valid && !hazard_stall);
    end
  end

  assign fetch_req_addr = pc_q;
  assign flush_ifid     = rst_n && redirect;
  assign flush_idex     = rst_n && redirect;
  assign redirect_count = cnt_q;

  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    if (!redirect) begin
      if (skid_full) begin
        out_valid = 1'b1;
        out_instr = skid_instr;
        out_pc    = skid_pc;
      end else if (rsp_keep && !hazard_stall) begin
        out_valid = 1'b1;
        out_instr = fetch_rsp_instr;
        out_pc    = tag_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = tgt;
    end else if (handshake) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
    unique case (state_q)
      ISSUE: begin
        if (handshake) state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_d = fetch_rsp_valid ? ISSUE : KILL;
        end else if (fetch_rsp_valid) begin
          state_d = handshake ? WAIT : ISSUE;
        end
      end
      KILL: begin
        if (fetch_rsp_valid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (handshake) tag_q <= pc_q;
      if (redirect)  cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized scoreboard bench for fetch_redirect_ctrl with a behavioural memory and fetch model.
module tb_fetch_redirect_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_redirect = 1'b0, trap_redirect = 1'b0, hazard_stall = 1'b0;
  logic [31:0] ex_target = '0, trap_target = '0;
  logic        fetch_req_valid, fetch_req_ready = 1'b0;
  logic [31:0] fetch_req_addr;
  logic        fetch_rsp_valid = 1'b0;
  logic [31:0] fetch_rsp_instr = '0;
  logic        out_valid, flush_ifid, flush_idex;
  logic [31:0] out_instr, out_pc, redirect_count;

  fetch_redirect_ctrl #(
    .ADDR_WIDTH(32),
    .RESET_PC  (RESET_PC),
    .CNT_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .trap_redirect  (trap_redirect),
    .trap_target    (trap_target),
    .hazard_stall   (hazard_stall),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_addr (fetch_req_addr),
    .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_instr(fetch_rsp_instr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          delivered = 0;
  exp_t        exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_cnt = '0;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          max_lat = 1;
  event        smp_ev;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r = $urandom_range(0, 7);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return 32'hFFFF_FFF8;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // mode 0: random, 1: forced ex redirect, 2: quiet streaming
  task automatic cycle(input bit rst_val, input int mode);
    bit redir, hs;
    @(negedge clk);
    rst_n = rst_val;
    if (rst_val && mem_pend && mem_cnt == 0) begin
      fetch_rsp_valid = 1'b1;
      fetch_rsp_instr = mem_word(mem_addr);
    end else begin
      fetch_rsp_valid = 1'b0;
      fetch_rsp_instr = $urandom;
      if (mem_pend && mem_cnt > 0) mem_cnt--;
    end
    ex_target   = rand_target();
    trap_target = rand_target();
    case (mode)
      0: begin
        ex_redirect     = ($urandom_range(0, 9) == 0);
        trap_redirect   = ($urandom_range(0, 11) == 0);
        hazard_stall    = ($urandom_range(0, 9) < 3);
        fetch_req_ready = ($urandom_range(0, 9) < 7);
      end
      1: begin
        ex_redirect     = 1'b1;
        trap_redirect   = 1'b0;
        hazard_stall    = 1'b0;
        fetch_req_ready = 1'b1;
      end
      default: begin
        ex_redirect     = 1'b0;
        trap_redirect   = 1'b0;
        hazard_stall    = 1'b0;
        fetch_req_ready = 1'b1;
      end
    endcase
    if (!rst_val) begin
      ex_redirect   = 1'b0;
      trap_redirect = 1'b0;
    end
    #2;
    -> smp_ev;
    #1;
    if (!rst_n) begin
      m_pc     = RESET_PC;
      m_cnt    = '0;
      mem_pend = 1'b0;
      exp_q.delete();
    end else begin
      redir = ex_redirect || trap_redirect;
      hs    = fetch_req_valid && fetch_req_ready;
      if (fetch_rsp_valid) mem_pend = 1'b0;
      if (hs) begin
        if (mem_pend) check("single_outstanding", 32'd2, 32'd1);
        mem_pend = 1'b1;
        mem_addr = fetch_req_addr;
        mem_cnt  = $urandom_range(0, max_lat - 1);
        exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      end
      if (redir) begin
        exp_q.delete();
        m_cnt++;
        m_pc = trap_redirect ? trap_target : ex_target;
      end else if (hs) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Monitor: compares DUT outputs against the model state of the current cycle.
  always @(smp_ev) begin
    bit redir_now;
    exp_t e;
    redir_now = ex_redirect || trap_redirect;
    if (!rst_n) begin
      check("rst_req_valid", {31'b0, fetch_req_valid}, 32'd0);
      check("rst_req_addr", fetch_req_addr, RESET_PC);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
      check("rst_count", redirect_count, 32'd0);
    end else begin
      check("flush_ifid", {31'b0, flush_ifid}, {31'b0, redir_now});
      check("flush_idex", {31'b0, flush_idex}, {31'b0, redir_now});
      check("redirect_count", redirect_count, m_cnt);
      check("req_addr", fetch_req_addr, m_pc);
      if (redir_now) begin
        check("redir_req_valid", {31'b0, fetch_req_valid}, 32'd0);
        check("redir_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", out_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q[0];
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          if (!hazard_stall) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    int d0;
    bit found;
    repeat (3) cycle(0, 2);

    // Streaming with 1-cycle memory: one instruction per cycle after the first.
    max_lat = 1;
    d0 = delivered;
    repeat (30) cycle(1, 2);
    check("throughput", {31'b0, (delivered - d0) >= 28}, 32'd1);

    max_lat = 3;
    d0 = delivered;
    repeat (2000) cycle(1, 0);
    check("random_progress", {31'b0, (delivered - d0) > 100}, 32'd1);

    // Redirect with a slow response in flight, then reset while the response is squashed.
    max_lat = 6;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1, 2);
      found = mem_pend && mem_cnt >= 2;
    end
    check("kill_setup", {31'b0, found}, 32'd1);
    cycle(1, 1);
    check("kill_no_out", {31'b0, out_valid}, 32'd0);
    cycle(0, 2);
    cycle(0, 2);
    max_lat = 1;
    repeat (10) cycle(1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
